// File: rtl/ysyx_22040895_fetch_buf.sv
// Instruction fetch unit: issues one 4-byte read at a time to instruction
// memory and queues the returned words, with their address and fault flag,
// in a small FIFO that decode drains through a valid/ready handshake.
module ysyx_22040895_fetch_buf #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i_fb,
   input  logic [63:0] dnpc_i_fb,
   output logic        mem_req_valid_o_fb,
   input  logic        mem_req_ready_i_fb,
   output logic [63:0] mem_req_addr_o_fb,
   input  logic        mem_rsp_valid_i_fb,
   input  logic [31:0] mem_rsp_data_i_fb,
   input  logic        mem_rsp_err_i_fb,
   output logic        inst_valid_o_fb,
   input  logic        inst_ready_i_fb,
   output logic [31:0] inst_o_fb,
   output logic [63:0] pc_o_fb,
   output logic        fault_o_fb
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t        state;
   logic [63:0]   fetch_pc;
   logic [63:0]   req_addr;
   logic          req_valid;
   logic          drop_pending;

   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [63:0]   pc_q    [DEPTH];
   logic [31:0]   inst_q  [DEPTH];
   logic          fault_q [DEPTH];

   logic          pop;
   logic          push;
   logic          handshake;
   logic [63:0]   target;
   logic [63:0]   next_addr;
   logic [CW-1:0] count_after;

   assign target    = dnpc_i_fb & ~64'h3;
   assign next_addr = redirect_i_fb ? target : fetch_pc;
   assign handshake = (state == REQ) && mem_req_ready_i_fb;
   assign pop       = inst_valid_o_fb && inst_ready_i_fb;
   // A response arriving together with a redirect belongs to the old path.
   assign push      = (state == WAIT) && mem_rsp_valid_i_fb && !redirect_i_fb &&
                      ((count != FULL) || pop);

   // Occupancy after this cycle's push/pop, used to decide whether to refetch.
   always_comb begin
      count_after = count;
      case ({push, pop})
         2'b10:   count_after = count + CW'(1);
         2'b01:   count_after = count - CW'(1);
         default: count_after = count;
      endcase
   end

   assign mem_req_valid_o_fb = req_valid;
   assign mem_req_addr_o_fb  = req_addr;
   assign inst_valid_o_fb    = (count != '0);
   assign inst_o_fb          = inst_q[rd_ptr];
   assign pc_o_fb            = pc_q[rd_ptr];
   assign fault_o_fb         = fault_q[rd_ptr];

   // Fetch FSM: request issue, response tracking and redirect bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         fetch_pc     <= RESET_PC;
         req_addr     <= RESET_PC;
         req_valid    <= 1'b0;
         drop_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect_i_fb || (count < FULL)) begin
                  state     <= REQ;
                  req_valid <= 1'b1;
                  req_addr  <= next_addr;
               end
            end
            REQ: begin
               if (handshake) begin
                  req_valid    <= 1'b0;
                  drop_pending <= 1'b0;
                  if (redirect_i_fb || drop_pending) begin
                     state <= DROP;
                  end else begin
                     state    <= WAIT;
                     fetch_pc <= fetch_pc + 64'd4;
                  end
               end else if (redirect_i_fb) begin
                  // Address and valid stay frozen until memory accepts.
                  drop_pending <= 1'b1;
               end
            end
            WAIT: begin
               if (mem_rsp_valid_i_fb) begin
                  if (redirect_i_fb || (count_after < FULL)) begin
                     state     <= REQ;
                     req_valid <= 1'b1;
                     req_addr  <= next_addr;
                  end else begin
                     state <= IDLE;
                  end
               end else if (redirect_i_fb) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (mem_rsp_valid_i_fb) begin
                  state     <= REQ;
                  req_valid <= 1'b1;
                  req_addr  <= next_addr;
               end
            end
            default: state <= IDLE;
         endcase
         // Redirect target always wins; repeated redirects keep the last one.
         if (redirect_i_fb) begin
            fetch_pc <= target;
         end
      end
   end

   // Instruction FIFO; a redirect flushes it regardless of any same-cycle pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            inst_q[i]  <= '0;
            fault_q[i] <= 1'b0;
         end
      end else if (redirect_i_fb) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            pc_q[wr_ptr]    <= req_addr;
            inst_q[wr_ptr]  <= mem_rsp_err_i_fb ? 32'h0 : mem_rsp_data_i_fb;
            fault_q[wr_ptr] <= mem_rsp_err_i_fb;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count_after;
      end
   end

endmodule
